aha_clock_gate_ctrl: RTL and testbench

Q-channel clock-gating controller that drives the `E` input of the integrated clock-gate cell for one peripheral clock domain. It counts consecutive idle cycles and requests quiescence from the device over a Q-channel handshake (`QREQn`/`QACCEPTn`/`QDENY`). It gates the clock only after the device accepts the request, and restores the clock before withdrawing the request on wake.

---
 rtl/aha_clock_gate_ctrl.sv | 103 ++++++++++
 tb/tb_aha_clock_gate_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aha_clock_gate_ctrl.sv
// Q-channel clock-gating controller for one peripheral clock domain.
// Counts consecutive idle cycles, requests quiescence over QREQn/QACCEPTn/QDENY,
// drops the ICG enable only after accept and restores it before withdrawing the request.
module aha_clock_gate_ctrl #(
  parameter int unsigned IDLE_CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  CG_EN_SW,
  input  logic [IDLE_CNT_W-1:0] IDLE_THRESH,
  input  logic                  ACTIVE,
  input  logic                  QACCEPTn,
  input  logic                  QDENY,
  output logic                  QREQn,
  output logic                  CLK_EN,
  output logic                  GATED,
  output logic [2:0]            STATE
);

  localparam logic [2:0] StRun     = 3'd0;
  localparam logic [2:0] StRequest = 3'd1;
  localparam logic [2:0] StStopped = 3'd2;
  localparam logic [2:0] StWake    = 3'd3;
  localparam logic [2:0] StExit    = 3'd4;
  localparam logic [2:0] StDenied  = 3'd5;

  localparam logic [IDLE_CNT_W-1:0] CntOne = IDLE_CNT_W'(1);

  logic [2:0]            state_q, state_d;
  logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  qreqn_q, qreqn_d;
  logic                  clk_en_q, clk_en_d;
  logic                  gated_q, gated_d;
  logic                  idle;

  assign idle = CG_EN_SW & ~ACTIVE;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (idle && (cnt_q >= IDLE_THRESH)) state_d = StRequest;
      // Deny wins over a simultaneous accept so the clock stays on.
      StRequest: begin
        if (QDENY)          state_d = StDenied;
        else if (!QACCEPTn) state_d = StStopped;
      end
      StStopped: if (ACTIVE || !CG_EN_SW) state_d = StWake;
      StWake:    state_d = StExit;
      StExit:    if (QACCEPTn) state_d = StRun;
      StDenied:  if (!QDENY) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  // Idle counter: counts only while staying in RUN; any entry into RUN starts from zero
  always_comb begin
    cnt_d = '0;
    if ((state_q == StRun) && (state_d == StRun) && idle) begin
      cnt_d = (cnt_q == {IDLE_CNT_W{1'b1}}) ? cnt_q : cnt_q + CntOne;
    end
  end

  // Output decode from next state so outputs are registered alongside the state
  always_comb begin
    qreqn_d  = 1'b1;
    clk_en_d = 1'b1;
    gated_d  = 1'b0;
    unique case (state_d)
      StRequest: qreqn_d = 1'b0;
      StStopped: begin
        qreqn_d  = 1'b0;
        clk_en_d = 1'b0;
        gated_d  = 1'b1;
      end
      StWake:    qreqn_d = 1'b0;
      default:   ;
    endcase
  end

  // State, counter and output registers; reset forces the clock on immediately
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      qreqn_q  <= 1'b1;
      clk_en_q <= 1'b1;
      gated_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qreqn_q  <= qreqn_d;
      clk_en_q <= clk_en_d;
      gated_q  <= gated_d;
    end
  end

  assign QREQn  = qreqn_q;
  assign CLK_EN = clk_en_q;
  assign GATED  = gated_q;
  assign STATE  = state_q;

endmodule

// File: tb/tb_aha_clock_gate_ctrl.sv
// Self-checking bench for aha_clock_gate_ctrl: directed vector table, hand sequences
// for threshold/reset corners, and randomized stimulus against a behavioural model.
module tb_aha_clock_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw, act, qa, qd;
  logic [7:0] thr;
  logic       qreqn, clk_en, gated;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aha_clock_gate_ctrl #(.IDLE_CNT_W(8)) dut (
    .CLK         (clk),
    .RESETn      (rst_n),
    .CG_EN_SW    (sw),
    .IDLE_THRESH (thr),
    .ACTIVE      (act),
    .QACCEPTn    (qa),
    .QDENY       (qd),
    .QREQn       (qreqn),
    .CLK_EN      (clk_en),
    .GATED       (gated),
    .STATE       (state)
  );

  typedef struct {
    bit sw; bit act; bit qa; bit qd;
    bit q;  bit c;   bit g;  int st;
  } vec_t;
  vec_t tbl[$];

  typedef enum int {MRun, MReq, MStop, MWake, MExit, MDeny} mode_t;
  mode_t m_mode;
  int    m_streak;

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic chk_outs(input string name, input bit q, input bit c, input bit g, input int st);
    chk({name, ".QREQn"}, int'(qreqn), int'(q));
    chk({name, ".CLK_EN"}, int'(clk_en), int'(c));
    chk({name, ".GATED"}, int'(gated), int'(g));
    chk({name, ".STATE"}, int'(state), st);
  endtask

  // Drive at negedge, let one rising edge pass, land on the next negedge.
  task automatic cycle(input bit s, input bit a, input bit acc, input bit dn);
    sw = s; act = a; qa = acc; qd = dn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input bit s, input bit a, input bit acc, input bit dn,
                     input bit q, input bit c, input bit g, input int st);
    vec_t v;
    v.sw = s; v.act = a; v.qa = acc; v.qd = dn;
    v.q = q; v.c = c; v.g = g; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #13;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model: spec rules over an unbounded idle streak count
  task automatic model_step(input bit s, input bit a, input bit acc, input bit dn, input int t);
    case (m_mode)
      MRun: begin
        if (s && !a) begin
          m_streak++;
          if (m_streak >= t + 1) begin m_mode = MReq; m_streak = 0; end
        end else m_streak = 0;
      end
      MReq:  if (dn) m_mode = MDeny; else if (!acc) m_mode = MStop;
      MStop: if (a || !s) m_mode = MWake;
      MWake: m_mode = MExit;
      MExit: if (acc) begin m_mode = MRun; m_streak = 0; end
      MDeny: if (!dn) begin m_mode = MRun; m_streak = 0; end
      default: m_mode = MRun;
    endcase
  endtask

  function automatic bit [5:0] model_outs(input mode_t md);
    // {QREQn, CLK_EN, GATED, STATE}
    case (md)
      MRun:    return {3'b110, 3'd0};
      MReq:    return {3'b010, 3'd1};
      MStop:   return {3'b001, 3'd2};
      MWake:   return {3'b010, 3'd3};
      MExit:   return {3'b110, 3'd4};
      default: return {3'b110, 3'd5};
    endcase
  endfunction

  initial begin
    bit gone;
    rst_n = 1'b0; sw = 1'b0; act = 1'b0; qa = 1'b1; qd = 1'b0; thr = 8'd3;
    #12;
    chk_outs("reset", 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, IDLE_THRESH=3
    add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0);
    add(1,0,1,0, 0,1,0,1);                                // QREQn falls at edge 4
    add(1,1,1,0, 0,1,0,1);                                // ACTIVE ignored in REQUEST
    add(1,0,0,0, 0,0,1,2); add(1,0,0,0, 0,0,1,2);         // accept -> gated
    add(1,1,0,0, 0,1,0,3);                                // wake: CLK_EN back first
    add(1,0,0,0, 1,1,0,4); add(1,0,0,0, 1,1,0,4);         // QREQn up, wait for QACCEPTn
    add(1,0,1,0, 1,1,0,0);
    add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0);
    add(1,1,1,0, 1,1,0,0);                                // activity clears hysteresis
    add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0);
    add(1,0,1,0, 0,1,0,1);
    add(1,0,0,1, 1,1,0,5);                                // deny beats accept
    add(1,0,1,1, 1,1,0,5);
    add(1,0,1,0, 1,1,0,0);
    add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0); add(1,0,1,0, 1,1,0,0);
    add(1,0,1,0, 0,1,0,1);
    add(1,0,0,0, 0,0,1,2);
    add(0,0,0,0, 0,1,0,3);                                // software override wakes
    add(0,0,0,0, 1,1,0,4);
    add(0,0,1,0, 1,1,0,0);
    for (int i = 0; i < 6; i++) add(0,0,1,0, 1,1,0,0);    // never requests with SW off

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].sw, tbl[i].act, tbl[i].qa, tbl[i].qd);
      chk_outs($sformatf("vec%0d", i), tbl[i].q, tbl[i].c, tbl[i].g, tbl[i].st);
    end

    // Threshold 0: one idle cycle suffices
    thr = 8'd0;
    cycle(1, 0, 1, 0);
    chk_outs("thr0", 1'b0, 1'b1, 1'b0, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 0);
    chk_outs("thr0_back", 1'b1, 1'b1, 1'b0, 0);

    // Threshold 255: 256 idle cycles, last compare at the saturation point
    thr = 8'd255;
    for (int i = 0; i < 255; i++) cycle(1, 0, 1, 0);
    chk_outs("thr255_pre", 1'b1, 1'b1, 1'b0, 0);
    cycle(1, 0, 1, 0);
    chk_outs("thr255_req", 1'b0, 1'b1, 1'b0, 1);
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 0);

    // Async reset mid-RUN, no clock edge
    thr = 8'd3;
    cycle(1, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_outs("rst_run", 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model
    m_mode = MRun; m_streak = 0;
    for (int n = 0; n < 4000; n++) begin
      bit [5:0] ev;
      ev = model_outs(m_mode);
      chk($sformatf("rand%0d", n), int'({qreqn, clk_en, gated, state}), int'(ev));
      if (n % 250 == 0) thr = 8'($urandom_range(0, 6));
      sw  = ($urandom_range(0, 9) != 0);
      act = ($urandom_range(0, 4) == 0);
      qa  = $urandom_range(0, 1) != 0;
      qd  = ($urandom_range(0, 6) == 0);
      @(posedge clk);
      model_step(sw, act, qa, qd, int'(thr));
      @(negedge clk);
    end

    // Async reset while gated: clock must come back without an edge
    do_reset();
    thr = 8'd1;
    gone = 1'b0;
    for (int i = 0; i < 50 && !gone; i++) begin
      cycle(1, 0, 0, 0);
      gone = gated;
    end
    chk("reach_stopped", int'(gone), 1);
    #2 rst_n = 1'b0;
    #1 chk_outs("rst_stopped", 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
